// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: CPU io bus bundle for the UART transmitter.
// The CPU side drives address/strobe/data; the UART returns read data.
interface io_uart_tx_if;
    logic [31:0] addr;
    logic        ce;
    logic        iow;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output ce,
        output iow,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  ce,
        input  iow,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter.
// Byte FIFO, programmable baud divider and START/DATA/STOP shift FSM.
module io_uart_tx #(
    parameter logic [31:0] BASE       = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    io_uart_tx_if.slave bus,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_ovf;

    logic [15:0]   r_baud_div;
    logic [15:0]   r_bit_div;
    logic [15:0]   w_bit_div_nxt;
    logic [15:0]   r_baud_cnt;
    logic [15:0]   w_baud_cnt_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          r_irq;
    logic          w_irq_nxt;

    logic          w_sel;
    logic          w_wr;
    logic          w_rd;
    logic [1:0]    w_off;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_bit_end;
    logic [15:0]   w_div_wr;
    logic [4:0]    w_count5;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Address decode and register-write qualifiers.
    assign w_sel      = bus.ce && (bus.addr[31:4] == BASE[31:4]);
    assign w_wr       = w_sel && bus.iow;
    assign w_rd       = w_sel && !bus.iow;
    assign w_off      = bus.addr[3:2];
    assign w_unused   = ^{bus.addr[1:0], bus.wdata[31:16]};

    // FIFO flags; full is judged on the pre-edge count.
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = w_wr && (w_off == 2'd0);
    assign w_push     = w_push_req && !w_full;

    // Divider writes below 2 clamp to 2 so a bit always spans two clocks.
    assign w_div_wr   = (bus.wdata[15:0] < 16'd2) ? 16'd2
                                                  : bus.wdata[15:0];

    assign w_bit_end  = (r_baud_cnt == (r_bit_div - 16'd1));
    assign w_count5   = 5'(r_count);

    assign w_status   = {23'd0, w_count5, r_ovf, w_busy, w_empty, w_full};

    // Combinational read mux; zero unless this block is read.
    always_comb begin
        w_rdata = 32'h0;
        if (w_rd) begin
            unique case (w_off)
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = {16'h0, r_baud_div};
                default: w_rdata = 32'h0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;

    // FSM next state, pop request and shift datapath.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_shift_nxt    = r_shift;
        w_bit_div_nxt  = r_bit_div;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = r_mem[r_rptr];
                    w_bit_div_nxt  = r_baud_div;
                    w_baud_cnt_nxt = 16'd0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = 16'd0;
                    w_bit_idx_nxt  = 3'd0;
                    w_state_nxt    = S_DATA;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = 16'd0;
                    w_shift_nxt    = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = 16'd0;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = r_mem[r_rptr];
                        w_bit_div_nxt = r_baud_div;
                        w_state_nxt   = S_START;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next serial level follows the state being entered.
    always_comb begin
        w_txd_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // Next FIFO occupancy and interrupt level.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
        w_irq_nxt = (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift datapath, baud counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= 8'h00;
            r_bit_div  <= DIV_RESET;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_txd      <= 1'b1;
            r_irq      <= 1'b1;
        end else begin
            r_shift    <= w_shift_nxt;
            r_bit_div  <= w_bit_div_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_txd      <= w_txd_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    // FIFO pointers, count, overflow flag and baud divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_baud_div <= DIV_RESET;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && (w_off == 2'd1) && bus.wdata[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_wr && (w_off == 2'd2)) begin
                r_baud_div <= w_div_wr;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.wdata[7:0];
        end
    end

    assign txd = r_txd;
    assign irq = r_irq;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed bench for io_uart_tx.
// Expected frames are queued at write time; a serial monitor checks them.
`timescale 1ns/1ps
module tb_io_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'd4;
    localparam logic [31:0] A_BD = BASE + 32'd8;
    localparam logic [31:0] A_RS = BASE + 32'd12;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic irq;

    io_uart_tx_if bus ();

    io_uart_tx #(
        .BASE       (BASE),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .txd (txd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    int   gap_log[64];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Both bus tasks start and end on a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.iow   = 1'b1;
        bus.ce    = 1'b1;
        @(negedge clk);
        bus.ce    = 1'b0;
        bus.iow   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.iow  = 1'b0;
        bus.ce   = 1'b1;
        #1 d = bus.rdata;
        bus.ce   = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] req,
                          input string name);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, req);
    endtask

    task automatic push_exp(input logic [7:0] data, input int div);
        exp_t e;
        e.data = data;
        e.div  = div;
        sb.push_back(e);
    endtask

    task automatic wait_frames(input int n, input int budget,
                               input string name);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames_done < n) begin
            errors++;
            $display("FAIL %s timeout frames=%0d required=%0d",
                     name, frames_done, n);
        end
    endtask

    // Serial monitor: samples txd on falling edges, checks every cycle
    // of each frame against the queued byte and divider.
    initial begin : monitor
        int         idle;
        int         bad;
        int         first_bad;
        bit         aborted;
        exp_t       e;
        logic [9:0] pat;
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || txd !== 1'b0) begin
                idle++;
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=start_bit required=idle");
                while (txd === 1'b0) @(negedge clk);
                idle = 0;
            end else begin
                e         = sb[0];
                pat       = {1'b1, e.data, 1'b0};
                bad       = 0;
                first_bad = -1;
                aborted   = 1'b0;
                for (int c = 0; c < 10 * e.div; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd !== pat[c / e.div]) begin
                        if (bad == 0) first_bad = c;
                        bad++;
                    end
                end
                if (!aborted) begin
                    void'(sb.pop_front());
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame_%02h actual=%0d_bad_cycles_from_%0d required=0_bad_div_%0d",
                                 e.data, bad, first_bad, e.div);
                    end
                    gap_log[frames_done % 64] = idle;
                    frames_done++;
                end
                idle = 0;
            end
        end
    end

    initial begin : stim
        int          base;
        int          lows;
        logic [31:0] d;

        rst       = 1'b1;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.iow   = 1'b0;
        bus.ce    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd1);
        rd_chk(A_ST, 32'h0000_0002, "reset_status");
        rd_chk(A_BD, 32'd868, "reset_bauddiv");
        rd_chk(A_TX, 32'h0, "txdata_reads_zero");
        rd_chk(A_RS, 32'h0, "reserved_reads_zero");
        rd_chk(32'h0000_0204, 32'h0, "unselected_reads_zero");
        bus.addr = A_ST;
        bus.iow  = 1'b0;
        bus.ce   = 1'b0;
        #1 chk("no_ce_reads_zero", bus.rdata, 32'h0);
        @(negedge clk);

        wr(A_BD, 32'd4);
        rd_chk(A_BD, 32'd4, "bauddiv_4");
        push_exp(8'hA5, 4);
        wr(A_TX, 32'h0000_00A5);
        chk("txd_high_before_pop", {31'd0, txd}, 32'd1);
        rd_chk(A_ST, 32'h0000_0010, "status_one_queued");
        chk("txd_low_after_pop", {31'd0, txd}, 32'd0);
        chk("irq_low_busy", {31'd0, irq}, 32'd0);
        wait_frames(1, 200, "frame_a5");
        @(negedge clk);
        chk("irq_after_frame", {31'd0, irq}, 32'd1);
        chk("txd_idle_after_frame", {31'd0, txd}, 32'd1);

        base = frames_done;
        push_exp(8'h3C, 4);
        push_exp(8'hC3, 4);
        push_exp(8'h81, 4);
        wr(A_TX, 32'h0000_003C);
        wr(A_TX, 32'h0000_00C3);
        wr(A_TX, 32'h0000_0081);
        rd_chk(A_ST, 32'h0000_0024, "status_count2_busy");
        wait_frames(base + 3, 400, "b2b_frames");
        chk("b2b_gap_1", gap_log[(base + 1) % 64], 32'd0);
        chk("b2b_gap_2", gap_log[(base + 2) % 64], 32'd0);
        repeat (2) @(negedge clk);

        base = frames_done;
        push_exp(8'h5A, 4);
        push_exp(8'hF0, 2);
        wr(A_TX, 32'h0000_005A);
        wr(A_TX, 32'h0000_00F0);
        wr(A_BD, 32'd2);
        rd_chk(A_BD, 32'd2, "bauddiv_midframe");
        wait_frames(base + 2, 300, "div_change_frames");
        wr(A_BD, 32'd0);
        rd_chk(A_BD, 32'd2, "bauddiv_clamp_0");
        wr(A_BD, 32'hFFFF_0001);
        rd_chk(A_BD, 32'd2, "bauddiv_clamp_1");
        wr(A_BD, 32'hABCD_0007);
        rd_chk(A_BD, 32'd7, "bauddiv_low16");
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (2) @(negedge clk);

        wr(A_BD, 32'd1000);
        push_exp(8'h00, 1000);
        for (int i = 0; i < 5; i++) wr(A_TX, 32'(i));
        rd_chk(A_ST, 32'h0000_0044, "status_count4");
        for (int i = 5; i < 10; i++) wr(A_TX, 32'(i));
        rd_chk(A_ST, 32'h0000_008D, "status_full_ovf");
        wr(A_ST, 32'h0000_0008);
        rd_chk(A_ST, 32'h0000_0085, "status_ovf_cleared");

        repeat (2000) @(negedge clk);
        chk("txd_low_in_data", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("txd_after_reset_edge", {31'd0, txd}, 32'd1);
        chk("irq_after_reset_edge", {31'd0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        rd_chk(A_ST, 32'h0000_0002, "status_after_reset");
        rd_chk(A_BD, 32'd868, "bauddiv_after_reset");
        base = frames_done;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_tx_after_reset", lows, 32'd0);
        chk("no_frames_after_reset", frames_done - base, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
